// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer. Takes a byte over a ready/start handshake, builds the 11-bit frame
// and strobes the Shift_Register load/shift inputs so one bit goes out per baud period.
module uart_tx_ctrl #(
    parameter int unsigned BAUD_DIV   = 5208,
    parameter bit          PARITY_EN  = 1'b1,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        tx_start_i,
    input  logic [7:0]  tx_data_i,
    output logic        tx_rdy_o,
    output logic        tx_done_o,
    output logic [10:0] sr_data_o,
    output logic        sr_load_o,
    output logic        sr_shift_o
);

    localparam int unsigned     CntW    = $clog2(BAUD_DIV);
    localparam logic [CntW-1:0] CntMax  = CntW'(BAUD_DIV - 1);
    localparam logic [3:0]      LastBit = 4'd10;

    typedef enum logic [1:0] {StIdle, StLoad, StSend} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] baud_cnt_q, baud_cnt_d, baud_cnt_inc;
    logic [3:0]      bit_cnt_q, bit_cnt_d;
    logic            tx_rdy_q, tx_rdy_d;
    logic            tx_done_q, tx_done_d;
    logic            sr_load_q, sr_load_d;
    logic            sr_shift_q, sr_shift_d;
    logic [10:0]     sr_data_q, sr_data_d;
    logic            accept, baud_tick, parity;

    assign accept       = (state_q == StIdle) && tx_start_i;
    // The baud period starts in the load cycle, so the counter runs in both busy states.
    assign baud_tick    = (state_q != StIdle) && (baud_cnt_q == CntMax);
    assign baud_cnt_inc = baud_tick ? '0 : baud_cnt_q + 1'b1;
    assign parity       = PARITY_EN ? ((^tx_data_i) ^ PARITY_ODD) : 1'b1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            tx_rdy_q   <= 1'b1;
            tx_done_q  <= 1'b0;
            sr_load_q  <= 1'b0;
            sr_shift_q <= 1'b0;
            sr_data_q  <= 11'h7FF;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            tx_rdy_q   <= tx_rdy_d;
            tx_done_q  <= tx_done_d;
            sr_load_q  <= sr_load_d;
            sr_shift_q <= sr_shift_d;
            sr_data_q  <= sr_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (tx_start_i) begin
                    state_d    = StLoad;
                    baud_cnt_d = '0;
                    bit_cnt_d  = '0;
                end
            end
            StLoad: begin
                state_d    = StSend;
                baud_cnt_d = baud_cnt_inc;
            end
            StSend: begin
                baud_cnt_d = baud_cnt_inc;
                if (baud_tick) begin
                    if (bit_cnt_q == LastBit) begin
                        state_d = StIdle;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        tx_rdy_d   = (state_d == StIdle);
        sr_load_d  = (state_d == StLoad);
        tx_done_d  = (state_q == StSend) && baud_tick && (bit_cnt_q == LastBit);
        sr_shift_d = (state_q == StSend) && baud_tick && (bit_cnt_q != LastBit);
        sr_data_d  = accept ? {1'b1, parity, tx_data_i, 1'b0} : sr_data_q;
    end

    assign tx_rdy_o   = tx_rdy_q;
    assign tx_done_o  = tx_done_q;
    assign sr_load_o  = sr_load_q;
    assign sr_shift_o = sr_shift_q;
    assign sr_data_o  = sr_data_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: three parity variants share stimulus; a timeline model predicts
// every output each cycle from the acceptance time of the current frame.
module tb_uart_tx_ctrl;

    localparam int B        = 4;
    localparam int FrameLen = 11 * B;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data = 8'h00;

    logic rdy_e, done_e, load_e, shift_e;
    logic rdy_o, done_o, load_o, shift_o;
    logic rdy_n, done_n, load_n, shift_n;
    logic [10:0] data_e, data_o, data_n;

    always #5 clk = ~clk;

    uart_tx_ctrl #(.BAUD_DIV(B), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut_even (
        .clk_i(clk), .rst_ni(rst_n), .tx_start_i(tx_start), .tx_data_i(tx_data),
        .tx_rdy_o(rdy_e), .tx_done_o(done_e), .sr_data_o(data_e),
        .sr_load_o(load_e), .sr_shift_o(shift_e)
    );
    uart_tx_ctrl #(.BAUD_DIV(B), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) dut_odd (
        .clk_i(clk), .rst_ni(rst_n), .tx_start_i(tx_start), .tx_data_i(tx_data),
        .tx_rdy_o(rdy_o), .tx_done_o(done_o), .sr_data_o(data_o),
        .sr_load_o(load_o), .sr_shift_o(shift_o)
    );
    uart_tx_ctrl #(.BAUD_DIV(B), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut_np (
        .clk_i(clk), .rst_ni(rst_n), .tx_start_i(tx_start), .tx_data_i(tx_data),
        .tx_rdy_o(rdy_n), .tx_done_o(done_n), .sr_data_o(data_n),
        .sr_load_o(load_n), .sr_shift_o(shift_n)
    );

    typedef struct {
        logic [7:0]  data;
        logic [10:0] even;
        logic [10:0] odd;
        logic [10:0] np;
    } vec_t;
    vec_t vecs[6];

    int checks = 0;
    int failures = 0;

    // Model state: frame accepted at posedge number acc, t counts posedges.
    int          t = 0;
    int          acc = 0;
    bit          act = 1'b0;
    bit          pend = 1'b0;
    logic [7:0]  pend_data = 8'h00;
    logic [10:0] fr_e = 11'h7FF, fr_o = 11'h7FF, fr_n = 11'h7FF;
    bit          e_rdy = 1'b1, e_done = 1'b0, e_load = 1'b0, e_shift = 1'b0;
    int          shifts_seen = 0;
    int          dones_seen = 0;
    int          load_t = -1;

    function automatic logic [10:0] ref_frame(input logic [7:0] d, input bit en, input bit odd);
        int   ones;
        logic p;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        p = en ? (((ones % 2) == 1) ^ odd) : 1'b1;
        return {1'b1, p, d, 1'b0};
    endfunction

    task automatic chk(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
        checks++;
        if (act_v !== exp_v) begin
            failures++;
            $display("FAIL %s t=%0d actual=%0h required=%0h", name, t, act_v, exp_v);
        end
    endtask

    task automatic chk_inst(input string tag, input logic r, input logic d, input logic l,
                            input logic s, input logic [10:0] dat, input logic [10:0] fr);
        chk({tag, ".rdy"}, 32'(r), 32'(e_rdy));
        chk({tag, ".done"}, 32'(d), 32'(e_done));
        chk({tag, ".load"}, 32'(l), 32'(e_load));
        chk({tag, ".shift"}, 32'(s), 32'(e_shift));
        chk({tag, ".data"}, 32'(dat), 32'(fr));
    endtask

    task automatic chk_reset(input string tag);
        e_rdy = 1'b1; e_done = 1'b0; e_load = 1'b0; e_shift = 1'b0;
        chk_inst({tag, ".even"}, rdy_e, done_e, load_e, shift_e, data_e, 11'h7FF);
        chk_inst({tag, ".odd"}, rdy_o, done_o, load_o, shift_o, data_o, 11'h7FF);
        chk_inst({tag, ".np"}, rdy_n, done_n, load_n, shift_n, data_n, 11'h7FF);
    endtask

    task automatic step(input logic s, input logic [7:0] d);
        int rel;
        @(posedge clk);
        t++;
        if (pend) begin
            act  = 1'b1;
            acc  = t;
            fr_e = ref_frame(pend_data, 1'b1, 1'b0);
            fr_o = ref_frame(pend_data, 1'b1, 1'b1);
            fr_n = ref_frame(pend_data, 1'b0, 1'b0);
            pend = 1'b0;
        end
        @(negedge clk);
        rel = t - acc;
        e_rdy = 1'b1; e_done = 1'b0; e_load = 1'b0; e_shift = 1'b0;
        if (act) begin
            if (rel < FrameLen) begin
                e_rdy   = 1'b0;
                e_load  = (rel == 0);
                e_shift = (rel > 0) && ((rel % B) == 0);
            end else if (rel == FrameLen) begin
                e_done = 1'b1;
            end else begin
                act = 1'b0;
            end
        end
        chk_inst("even", rdy_e, done_e, load_e, shift_e, data_e, fr_e);
        chk_inst("odd", rdy_o, done_o, load_o, shift_o, data_o, fr_o);
        chk_inst("np", rdy_n, done_n, load_n, shift_n, data_n, fr_n);
        if (load_e) begin
            shifts_seen = 0;
            load_t = t;
        end
        if (shift_e) shifts_seen++;
        if (done_e) dones_seen++;
        tx_start  = s;
        tx_data   = d;
        pend      = s && e_rdy;
        pend_data = d;
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (!e_rdy && guard < 100) begin
            step(1'b0, 8'h00);
            guard++;
        end
        chk("wait_idle_timeout", 32'(e_rdy), 32'd1);
    endtask

    initial begin
        int first_load, a, guard, done_before;

        vecs[0] = '{8'h41, 11'h482, 11'h682, 11'h682};
        vecs[1] = '{8'h00, 11'h400, 11'h600, 11'h600};
        vecs[2] = '{8'hFF, 11'h5FE, 11'h7FE, 11'h7FE};
        vecs[3] = '{8'h55, 11'h4AA, 11'h6AA, 11'h6AA};
        vecs[4] = '{8'h80, 11'h700, 11'h500, 11'h700};
        vecs[5] = '{8'hC3, 11'h586, 11'h786, 11'h786};

        #50;
        chk_reset("por");
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            wait_idle();
            step(1'b1, vecs[i].data);
            step(1'b0, 8'h00);
            chk("tbl.even", 32'(data_e), 32'(vecs[i].even));
            chk("tbl.odd", 32'(data_o), 32'(vecs[i].odd));
            chk("tbl.np", 32'(data_n), 32'(vecs[i].np));
            wait_idle();
            chk("tbl.shift_count", shifts_seen, 10);
        end

        // Start during a frame is dropped; start held at completion chains the next frame.
        wait_idle();
        step(1'b1, 8'h41);
        step(1'b0, 8'h00);
        first_load = load_t;
        a = acc;
        while (t < a + 9) step(1'b0, 8'h00);
        step(1'b1, 8'h99);
        step(1'b0, 8'h00);
        chk("ignored.data", 32'(data_e), 32'h482);
        while (t < a + 43) step(1'b0, 8'h00);
        guard = 0;
        while (load_t == first_load && guard < 60) begin
            step(1'b1, 8'h00);
            guard++;
        end
        step(1'b0, 8'h00);
        chk("b2b.load_gap", load_t - first_load, FrameLen + 1);
        chk("b2b.data", 32'(data_e), 32'h400);

        // Reset after the third shift.
        wait_idle();
        shifts_seen = 0;
        step(1'b1, 8'h41);
        guard = 0;
        while (shifts_seen < 3 && guard < 60) begin
            step(1'b0, 8'h00);
            guard++;
        end
        chk("mid.third_shift", shifts_seen, 3);
        done_before = dones_seen;
        #2;
        rst_n = 1'b0;
        act = 1'b0; pend = 1'b0;
        fr_e = 11'h7FF; fr_o = 11'h7FF; fr_n = 11'h7FF;
        #1;
        chk_reset("mid");
        repeat (3) @(posedge clk);
        #1;
        chk_reset("held");
        @(negedge clk);
        rst_n = 1'b1;
        e_rdy = 1'b1;
        for (int i = 0; i < 20; i++) step(1'b0, 8'h00);
        chk("mid.no_done", dones_seen, done_before);
        shifts_seen = 0;
        step(1'b1, 8'h55);
        step(1'b0, 8'h00);
        chk("post.even", 32'(data_e), 32'h4AA);
        chk("post.odd", 32'(data_o), 32'h6AA);
        wait_idle();
        chk("post.shift_count", shifts_seen, 10);

        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 2) == 0), 8'($urandom));
        end
        step(1'b0, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
